// File: rtl/aes_enc_stream.sv
// aes_enc_stream: iterative AES-128 encryption core with valid/ready streaming,
// optional CBC chaining, a reduced-round option and a submodule-stall watchdog.
//   clk, rst (sync, active-low)       clock / reset; submodules see ~rst
//   in_valid/in_ready, din, keyin     block input handshake and key
//   iv, mode, first                   CBC controls, sampled with the block
//   out_valid/out_ready, dout         ciphertext handshake
//   busy, err                         activity and sticky watchdog error
// Contains the round-step submodules (subbytes, shiftrows, mixcolumns,
// keysched), each with an ena/done handshake: done pulses one cycle after ena.

package aes_enc_stream_pkg;
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as a^254 (GF inverse, 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < 7; i++) v = gmul(gmul(v, v), a);
        v = gmul(v, v);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction
endpackage

module aes_subbytes (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [127:0] state_in,
    output logic [127:0] state_out,
    output logic         done
);
    import aes_enc_stream_pkg::*;
    logic [127:0] res;
    always_comb begin
        res = '0;
        for (int i = 0; i < 16; i++) res[8*i +: 8] = sbox(state_in[8*i +: 8]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            state_out <= '0;
        end else begin
            done <= ena & ~done;
            if (ena & ~done) state_out <= res;
        end
    end
endmodule

module aes_shiftrows (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [127:0] state_in,
    output logic [127:0] state_out,
    output logic         done
);
    logic [127:0] res;
    // Byte index = 4*col + row, byte 0 in the top bits; row r rotates left by r.
    always_comb begin
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8*(r + 4*c) -: 8] = state_in[127 - 8*(r + 4*((c + r) % 4)) -: 8];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            state_out <= '0;
        end else begin
            done <= ena & ~done;
            if (ena & ~done) state_out <= res;
        end
    end
endmodule

module aes_mixcolumns (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [127:0] state_in,
    output logic [127:0] state_out,
    output logic         done
);
    import aes_enc_stream_pkg::*;
    logic [127:0] res;
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = state_in[127 - 32*c -: 8];
            a1 = state_in[119 - 32*c -: 8];
            a2 = state_in[111 - 32*c -: 8];
            a3 = state_in[103 - 32*c -: 8];
            res[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            res[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            res[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            res[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            state_out <= '0;
        end else begin
            done <= ena & ~done;
            if (ena & ~done) state_out <= res;
        end
    end
endmodule

module aes_keysched (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [3:0]   round_in,
    input  logic [127:0] prev_key_in,
    output logic [127:0] key_out,
    output logic         done
);
    import aes_enc_stream_pkg::*;
    logic [127:0] res;
    always_comb begin
        logic [31:0] w3, t, n0, n1, n2, n3;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 1; i < 10; i++) if (4'(i) < round_in) rc = xtime(rc);
        w3 = prev_key_in[31:0];
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        n0 = prev_key_in[127:96] ^ t;
        n1 = prev_key_in[95:64] ^ n0;
        n2 = prev_key_in[63:32] ^ n1;
        n3 = w3 ^ n2;
        res = {n0, n1, n2, n3};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            key_out <= '0;
        end else begin
            done <= ena & ~done;
            if (ena & ~done) key_out <= res;
        end
    end
endmodule

module aes_enc_stream #(
    parameter int NR       = 10,
    parameter int CHAIN_EN = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    input  logic [127:0] keyin,
    input  logic [127:0] iv,
    input  logic         mode,
    input  logic         first,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout,
    output logic         busy,
    output logic         err
);
    typedef enum logic [2:0] {IDLE, SUB, SHIFT, MIX, KSCHED, KADD, OUT, ERR} fsm_e;

    localparam logic [3:0] NR_L    = 4'(NR);
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d, key_q, key_d, chain_q, chain_d, dout_q, dout_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   wd_q, wd_d;
    logic         in_ready_q, in_ready_d, out_valid_q, out_valid_d, err_q, err_d;
    logic         sub_ena_q, sub_ena_d, shift_ena_q, shift_ena_d;
    logic         mix_ena_q, mix_ena_d, ks_ena_q, ks_ena_d;
    logic         sub_done, shift_done, mix_done, ks_done, wait_st, cur_done, sub_rst;
    logic [127:0] sub_out, shift_out, mix_out, ks_out, cv;

    assign sub_rst = ~rst;
    assign cv = (CHAIN_EN != 0 && mode) ? (first ? iv : chain_q) : '0;

    aes_subbytes   u_sub   (.clk(clk), .rst(sub_rst), .ena(sub_ena_q), .state_in(state_q),
                            .state_out(sub_out), .done(sub_done));
    aes_shiftrows  u_shift (.clk(clk), .rst(sub_rst), .ena(shift_ena_q), .state_in(state_q),
                            .state_out(shift_out), .done(shift_done));
    aes_mixcolumns u_mix   (.clk(clk), .rst(sub_rst), .ena(mix_ena_q), .state_in(state_q),
                            .state_out(mix_out), .done(mix_done));
    aes_keysched   u_ks    (.clk(clk), .rst(sub_rst), .ena(ks_ena_q), .round_in(round_q),
                            .prev_key_in(key_q), .key_out(ks_out), .done(ks_done));

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            key_q       <= '0;
            chain_q     <= '0;
            dout_q      <= '0;
            round_q     <= '0;
            wd_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            sub_ena_q   <= 1'b0;
            shift_ena_q <= 1'b0;
            mix_ena_q   <= 1'b0;
            ks_ena_q    <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            key_q       <= key_d;
            chain_q     <= chain_d;
            dout_q      <= dout_d;
            round_q     <= round_d;
            wd_q        <= wd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            sub_ena_q   <= sub_ena_d;
            shift_ena_q <= shift_ena_d;
            mix_ena_q   <= mix_ena_d;
            ks_ena_q    <= ks_ena_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        key_d       = key_q;
        chain_d     = chain_q;
        dout_d      = dout_q;
        round_d     = round_q;
        wd_d        = wd_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        sub_ena_d   = sub_ena_q;
        shift_ena_d = shift_ena_q;
        mix_ena_d   = mix_ena_q;
        ks_ena_d    = ks_ena_q;
        wait_st     = 1'b0;
        cur_done    = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    state_d    = din ^ keyin ^ cv;
                    key_d      = keyin;
                    round_d    = 4'd1;
                    in_ready_d = 1'b0;
                    sub_ena_d  = 1'b1;
                    wd_d       = '0;
                    fsm_d      = SUB;
                end
            end
            SUB: begin
                wait_st  = 1'b1;
                cur_done = sub_done;
                if (sub_done) begin
                    state_d     = sub_out;
                    sub_ena_d   = 1'b0;
                    shift_ena_d = 1'b1;
                    wd_d        = '0;
                    fsm_d       = SHIFT;
                end
            end
            SHIFT: begin
                wait_st  = 1'b1;
                cur_done = shift_done;
                if (shift_done) begin
                    state_d     = shift_out;
                    shift_ena_d = 1'b0;
                    wd_d        = '0;
                    // The final round skips MixColumns.
                    if (round_q == NR_L) begin
                        ks_ena_d = 1'b1;
                        fsm_d    = KSCHED;
                    end else begin
                        mix_ena_d = 1'b1;
                        fsm_d     = MIX;
                    end
                end
            end
            MIX: begin
                wait_st  = 1'b1;
                cur_done = mix_done;
                if (mix_done) begin
                    state_d   = mix_out;
                    mix_ena_d = 1'b0;
                    ks_ena_d  = 1'b1;
                    wd_d      = '0;
                    fsm_d     = KSCHED;
                end
            end
            KSCHED: begin
                wait_st  = 1'b1;
                cur_done = ks_done;
                if (ks_done) begin
                    key_d    = ks_out;
                    ks_ena_d = 1'b0;
                    fsm_d    = KADD;
                end
            end
            KADD: begin
                state_d = state_q ^ key_q;
                if (round_q == NR_L) begin
                    dout_d      = state_q ^ key_q;
                    out_valid_d = 1'b1;
                    fsm_d       = OUT;
                end else begin
                    round_d   = round_q + 4'd1;
                    sub_ena_d = 1'b1;
                    wd_d      = '0;
                    fsm_d     = SUB;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    chain_d     = dout_q;
                    in_ready_d  = 1'b1;
                    fsm_d       = IDLE;
                end
            end
            ERR: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                err_d       = 1'b1;
                sub_ena_d   = 1'b0;
                shift_ena_d = 1'b0;
                mix_ena_d   = 1'b0;
                ks_ena_d    = 1'b0;
            end
            default: fsm_d = IDLE;
        endcase
        // Watchdog: the count reaching TIMEOUT on a still-waiting cycle aborts.
        if (wait_st && !cur_done) begin
            if (wd_q == WD_LAST) begin
                fsm_d       = ERR;
                err_d       = 1'b1;
                sub_ena_d   = 1'b0;
                shift_ena_d = 1'b0;
                mix_ena_d   = 1'b0;
                ks_ena_d    = 1'b0;
            end else begin
                wd_d = wd_q + 8'd1;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign err       = err_q;
    assign busy      = (fsm_q != IDLE) && (fsm_q != ERR);
endmodule

// File: tb/tb_aes_enc_stream.sv
module tb_aes_enc_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, mode, first, out_ready;
    logic [127:0] din, keyin, iv;
    logic         in_ready, out_valid, busy, err;
    logic         in_ready_e, out_valid_e, busy_e, err_e;
    logic         in_ready_t, out_valid_t, busy_t, err_t;
    logic [127:0] dout, dout_e, dout_t;

    aes_enc_stream dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .keyin(keyin), .iv(iv), .mode(mode), .first(first), .out_valid(out_valid),
        .out_ready(out_ready), .dout(dout), .busy(busy), .err(err));

    aes_enc_stream #(.CHAIN_EN(0)) dut_ecb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_e), .din(din),
        .keyin(keyin), .iv(iv), .mode(mode), .first(first), .out_valid(out_valid_e),
        .out_ready(out_ready), .dout(dout_e), .busy(busy_e), .err(err_e));

    aes_enc_stream #(.TIMEOUT(16)) dut_to (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t), .din(din),
        .keyin(keyin), .iv(iv), .mode(mode), .first(first), .out_valid(out_valid_t),
        .out_ready(out_ready), .dout(dout_t), .busy(busy_t), .err(err_t));

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [127:0] key, pt, ivv;
        logic         md, fst, hold;
        logic [127:0] exp, exp_ecb;
    } vec_t;
    vec_t vecs [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({v.name, "_in_ready"}, 128'(in_ready), 128'(1));
        din      = v.pt;
        keyin    = v.key;
        iv       = v.ivv;
        mode     = v.md;
        first    = v.fst;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble inputs: they must have been sampled only at the handshake.
        din   = ~v.pt;
        keyin = ~v.key;
        iv    = ~v.ivv;
        chk({v.name, "_busy"}, 128'(busy), 128'(1));
    endtask

    task automatic get(input vec_t v);
        int n = 0;
        while (out_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({v.name, "_out_valid"}, 128'(out_valid), 128'(1));
        chk({v.name, "_dout"}, dout, v.exp);
        chk({v.name, "_dout_ecbonly"}, dout_e, v.exp_ecb);
        chk({v.name, "_dout_to16"}, dout_t, v.exp);
        if (v.hold) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                chk($sformatf("hold%0d_dout", i), dout, v.exp);
                chk($sformatf("hold%0d_valid", i), 128'(out_valid), 128'(1));
                chk($sformatf("hold%0d_in_ready", i), 128'(in_ready), 128'(0));
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({v.name, "_valid_drop"}, 128'(out_valid), 128'(0));
        chk({v.name, "_dout_held"}, dout, v.exp);
    endtask

    initial begin
        int  n;
        logic seen;
        vecs[0] = '{"c1", 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h0, 1'b0, 1'b0, 1'b0,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{"fipsb", 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h0, 1'b0, 1'b0, 1'b1,
                    128'h3925841d02dc09fbdc118597196a0b32, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{"cbc1", 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
                    128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b1, 1'b0,
                    128'h7649abac8119b246cee98e9b12e9197d, 128'h3ad77bb40d7a3660a89ecaf32466ef97};
        vecs[3] = '{"cbc2", 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                    128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b0, 1'b0,
                    128'h5086cb9b507219ee95db113a917678b2, 128'hf5d3d58503b9699de785895a96fdbaaf};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; first = 1'b0;
        din = '0; keyin = '0; iv = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_dout", dout, 128'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready_rise", 128'(in_ready), 128'(1));

        for (int i = 0; i < 4; i++) begin
            send(vecs[i]);
            get(vecs[i]);
        end

        // Watchdog: mixcolumns never completes in the TIMEOUT=16 instance.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        force dut_to.mix_done = 1'b0;
        send(vecs[0]);
        n = 0;
        while (dut_to.mix_ena_q !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wd_mix_entry", 128'(dut_to.mix_ena_q), 128'(1));
        n = 0;
        while (err_t !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wd_latency", 128'(n), 128'(16));
        chk("wd_err", 128'(err_t), 128'(1));
        chk("wd_busy", 128'(busy_t), 128'(0));
        chk("wd_out_valid", 128'(out_valid_t), 128'(0));
        chk("wd_in_ready", 128'(in_ready_t), 128'(0));
        repeat (5) @(negedge clk);
        chk("wd_sticky", 128'(err_t), 128'(1));
        release dut_to.mix_done;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("wd_rst_err", 128'(err_t), 128'(0));
        @(negedge clk);
        chk("wd_rst_ready", 128'(in_ready_t), 128'(1));

        // Reset during round 5 abandons the block.
        send(vecs[0]);
        n = 0;
        while (dut.round_q !== 4'd5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_round5", 128'(dut.round_q), 128'(5));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("mid_no_output", 128'(seen), 128'(0));
        send(vecs[0]);
        get(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
